// File: rtl/ysyx_22050710_csr_pkg.sv
// Shared definitions for the ysyx_22050710 machine-mode CSR file:
// CSR addresses, access op encodings, status bit positions and cause codes.
package ysyx_22050710_csr_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MISA     = 12'h301;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET = 12'hB02;
   localparam logic [11:0] CSR_MHARTID  = 12'hF14;

   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RW   = 2'b01,
      CSR_OP_RS   = 2'b10,
      CSR_OP_RC   = 2'b11
   } csr_op_e;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;
   localparam int MIE_MTIE       = 7;
   localparam int MIP_MTIP       = 7;

   localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
   localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;

endpackage

// File: rtl/ysyx_22050710_csr_counter.sv
// Free-running XLEN-bit counter with a write port that overrides the increment.
module ysyx_22050710_csr_counter #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inc_en,
   input  logic            wr_en,
   input  logic [XLEN-1:0] wr_data,
   output logic [XLEN-1:0] count
);

   // NOTE: state is updated with non-blocking assignments under an async reset
   // so every register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (wr_en) begin
         count <= wr_data;
      end else if (inc_en) begin
         count <= count + XLEN'(1);
      end
   end

endmodule

// File: rtl/ysyx_22050710_csr_file.sv
// Machine-mode CSR file with atomic csrrw/csrrs/csrrc, trap/mret sequencing,
// counters, timer-interrupt pending logic and illegal-access detection.
module ysyx_22050710_csr_file
   import ysyx_22050710_csr_pkg::*;
#(
   parameter int              XLEN          = 64,
   parameter logic [XLEN-1:0] MSTATUS_RESET = XLEN'(64'ha0000_1800),
   parameter logic [XLEN-1:0] MTVEC_RESET   = '0,
   parameter bit              HAS_COUNTERS  = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_csr_valid,
   input  logic [1:0]      i_csr_op,
   input  logic [11:0]     i_csr_addr,
   input  logic [XLEN-1:0] i_csr_wdata,
   input  logic            i_trap,
   input  logic [XLEN-1:0] i_trap_cause,
   input  logic [XLEN-1:0] i_trap_pc,
   input  logic [XLEN-1:0] i_trap_tval,
   input  logic            i_mret,
   input  logic            i_instret,
   input  logic            i_timer_irq,
   output logic [XLEN-1:0] o_rdata,
   output logic            o_illegal,
   output logic            o_redirect,
   output logic [XLEN-1:0] o_redirect_pc,
   output logic            o_irq_pending
);

   localparam logic [1:0]      MXL      = (XLEN == 64) ? 2'b10 : 2'b01;
   localparam logic [XLEN-1:0] MISA_VAL = {MXL, {(XLEN-15){1'b0}}, 13'h1100};

   csr_op_e op;
   assign op = csr_op_e'(i_csr_op);

   logic            mstatus_mie, mstatus_mpie, mie_mtie, mip_mtip;
   logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval, mcycle, minstret;
   logic [XLEN-1:0] mstatus_val, mie_val, mip_val;
   logic [XLEN-1:0] old_val, new_val;
   logic            addr_known, csr_access, is_write, read_only, illegal_raw, csr_we;

   always_comb begin
      mstatus_val = MSTATUS_RESET;
      mstatus_val[MSTATUS_MIE]  = mstatus_mie;
      mstatus_val[MSTATUS_MPIE] = mstatus_mpie;
      mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      mie_val = '0;
      mie_val[MIE_MTIE] = mie_mtie;
      mip_val = '0;
      mip_val[MIP_MTIP] = mip_mtip;
   end

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned and a latch is never inferred.
   always_comb begin
      old_val    = '0;
      addr_known = 1'b1;
      case (i_csr_addr)
         CSR_MSTATUS:  old_val = mstatus_val;
         CSR_MISA:     old_val = MISA_VAL;
         CSR_MIE:      old_val = mie_val;
         CSR_MTVEC:    old_val = mtvec;
         CSR_MSCRATCH: old_val = mscratch;
         CSR_MEPC:     old_val = mepc;
         CSR_MCAUSE:   old_val = mcause;
         CSR_MTVAL:    old_val = mtval;
         CSR_MIP:      old_val = mip_val;
         CSR_MCYCLE:   old_val = mcycle;
         CSR_MINSTRET: old_val = minstret;
         CSR_MHARTID:  old_val = '0;
         default:      addr_known = 1'b0;
      endcase
   end

   always_comb begin
      new_val = i_csr_wdata;
      case (op)
         CSR_OP_RS: new_val = old_val | i_csr_wdata;
         CSR_OP_RC: new_val = old_val & ~i_csr_wdata;
         default:   new_val = i_csr_wdata;
      endcase
   end

   // Set/clear with a zero mask is a pure read, so it may target read-only CSRs.
   assign csr_access  = i_csr_valid && (op != CSR_OP_NONE);
   assign is_write    = (op == CSR_OP_RW) || (i_csr_wdata != '0);
   assign read_only   = (i_csr_addr[11:10] == 2'b11) || (i_csr_addr == CSR_MISA);
   assign illegal_raw = csr_access && (!addr_known || (is_write && read_only));
   assign csr_we      = csr_access && is_write && !illegal_raw && !i_trap && !i_mret;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mstatus_mie  <= MSTATUS_RESET[MSTATUS_MIE];
         mstatus_mpie <= MSTATUS_RESET[MSTATUS_MPIE];
         mie_mtie     <= 1'b0;
         mip_mtip     <= 1'b0;
         mtvec        <= {MTVEC_RESET[XLEN-1:2], 1'b0, MTVEC_RESET[0]};
         mscratch     <= '0;
         mepc         <= '0;
         mcause       <= '0;
         mtval        <= '0;
      end else begin
         mip_mtip <= i_timer_irq;
         if (i_trap) begin
            mepc         <= {i_trap_pc[XLEN-1:2], 2'b00};
            mcause       <= i_trap_cause;
            mtval        <= i_trap_tval;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
         end else if (i_mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
         end else if (csr_we) begin
            case (i_csr_addr)
               CSR_MSTATUS: begin
                  mstatus_mie  <= new_val[MSTATUS_MIE];
                  mstatus_mpie <= new_val[MSTATUS_MPIE];
               end
               CSR_MIE:      mie_mtie <= new_val[MIE_MTIE];
               CSR_MTVEC:    mtvec    <= {new_val[XLEN-1:2], 1'b0, new_val[0]};
               CSR_MSCRATCH: mscratch <= new_val;
               CSR_MEPC:     mepc     <= {new_val[XLEN-1:2], 2'b00};
               CSR_MCAUSE:   mcause   <= new_val;
               CSR_MTVAL:    mtval    <= new_val;
               default:      ;
            endcase
         end
      end
   end

   logic wr_mcycle, wr_minstret;
   assign wr_mcycle   = csr_we && (i_csr_addr == CSR_MCYCLE);
   assign wr_minstret = csr_we && (i_csr_addr == CSR_MINSTRET);

   generate
      if (HAS_COUNTERS) begin : g_counters
         ysyx_22050710_csr_counter #(.XLEN(XLEN)) u_mcycle (
            .clk     (i_clk),
            .rst_n   (i_rst_n),
            .inc_en  (1'b1),
            .wr_en   (wr_mcycle),
            .wr_data (new_val),
            .count   (mcycle)
         );
         ysyx_22050710_csr_counter #(.XLEN(XLEN)) u_minstret (
            .clk     (i_clk),
            .rst_n   (i_rst_n),
            .inc_en  (i_instret),
            .wr_en   (wr_minstret),
            .wr_data (new_val),
            .count   (minstret)
         );
      end else begin : g_no_counters
         assign mcycle   = '0;
         assign minstret = '0;
      end
   endgenerate

   logic [XLEN-1:0] vec_base, vec_off;
   assign vec_base = {mtvec[XLEN-1:2], 2'b00};
   assign vec_off  = (mtvec[1:0] == 2'b01 && i_trap_cause[XLEN-1])
                   ? XLEN'({i_trap_cause[5:0], 2'b00}) : '0;

   // Control outputs are forced low while reset is held, even with i_trap high.
   always_comb begin
      o_redirect_pc = '0;
      if (i_rst_n) begin
         if (i_trap)      o_redirect_pc = vec_base + vec_off;
         else if (i_mret) o_redirect_pc = mepc;
      end
   end

   assign o_redirect    = i_rst_n && (i_trap || i_mret);
   assign o_illegal     = i_rst_n && illegal_raw;
   assign o_rdata       = (csr_access && !illegal_raw) ? old_val : '0;
   assign o_irq_pending = mstatus_mie && mie_mtie && mip_mtip;

endmodule

// File: tb/tb_ysyx_22050710_csr_file.sv
// Directed self-checking bench for the ysyx_22050710 CSR file: a vector table
// of single-cycle accesses plus hand-written trap, counter and reset sequences.
module tb_ysyx_22050710_csr_file;
   import ysyx_22050710_csr_pkg::*;

   logic        clk, rst_n;
   logic        csr_valid;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [63:0] csr_wdata;
   logic        trap;
   logic [63:0] trap_cause, trap_pc, trap_tval;
   logic        mret, instret, timer_irq;
   logic [63:0] rdata;
   logic        illegal, redirect, irq_pending;
   logic [63:0] redirect_pc;

   int pass_cnt = 0;
   int total_cnt = 0;

   localparam logic [1:0] RW = 2'b01;
   localparam logic [1:0] RS = 2'b10;
   localparam logic [1:0] RC = 2'b11;

   ysyx_22050710_csr_file dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_csr_valid   (csr_valid),
      .i_csr_op      (csr_op),
      .i_csr_addr    (csr_addr),
      .i_csr_wdata   (csr_wdata),
      .i_trap        (trap),
      .i_trap_cause  (trap_cause),
      .i_trap_pc     (trap_pc),
      .i_trap_tval   (trap_tval),
      .i_mret        (mret),
      .i_instret     (instret),
      .i_timer_irq   (timer_irq),
      .o_rdata       (rdata),
      .o_illegal     (illegal),
      .o_redirect    (redirect),
      .o_redirect_pc (redirect_pc),
      .o_irq_pending (irq_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [11:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp_rdata;
      logic        exp_illegal;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_op_drive(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd);
      csr_valid = 1'b1;
      csr_op    = op;
      csr_addr  = addr;
      csr_wdata = wd;
      next_cycle();
      csr_valid = 1'b0;
      csr_op    = 2'b00;
   endtask

   task automatic csr_read(input string name, input logic [11:0] addr, input logic [63:0] exp);
      csr_valid = 1'b1;
      csr_op    = RS;
      csr_addr  = addr;
      csr_wdata = '0;
      @(negedge clk);
      check(name, rdata, exp);
      next_cycle();
      csr_valid = 1'b0;
      csr_op    = 2'b00;
   endtask

   initial begin
      vecs[0]  = '{RS, 12'h300, 64'd0,                  64'h0000_000a_0000_1800, 1'b0};
      vecs[1]  = '{RS, 12'hF14, 64'd0,                  64'd0,                   1'b0};
      vecs[2]  = '{RW, 12'h340, 64'h0000_0000_dead_beef, 64'd0,                  1'b0};
      vecs[3]  = '{RS, 12'h340, 64'h0000_0000_000F_0000, 64'h0000_0000_dead_beef, 1'b0};
      vecs[4]  = '{RC, 12'h340, 64'h0000_0000_deaf_beef, 64'h0000_0000_deaf_beef, 1'b0};
      vecs[5]  = '{RS, 12'h340, 64'd0,                  64'd0,                   1'b0};
      vecs[6]  = '{RW, 12'hF14, 64'd5,                  64'd0,                   1'b1};
      vecs[7]  = '{RS, 12'hF14, 64'd0,                  64'd0,                   1'b0};
      vecs[8]  = '{RS, 12'h7C0, 64'd0,                  64'd0,                   1'b1};
      vecs[9]  = '{RW, 12'h301, 64'd0,                  64'd0,                   1'b1};
      vecs[10] = '{RS, 12'h301, 64'd0,                  64'h8000_0000_0000_1100, 1'b0};
      vecs[11] = '{RW, 12'h305, 64'h0000_0000_0000_FFFF, 64'd0,                  1'b0};
      vecs[12] = '{RS, 12'h305, 64'd0,                  64'h0000_0000_0000_FFFD, 1'b0};
      vecs[13] = '{RW, 12'h341, 64'h13,                 64'd0,                   1'b0};
      vecs[14] = '{RS, 12'h341, 64'd0,                  64'h10,                  1'b0};
      vecs[15] = '{RW, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_000a_0000_1800, 1'b0};
      vecs[16] = '{RS, 12'h300, 64'd0,                  64'h0000_000a_0000_1888, 1'b0};
      vecs[17] = '{RC, 12'h300, 64'h88,                 64'h0000_000a_0000_1888, 1'b0};
      vecs[18] = '{RW, 12'h344, 64'h80,                 64'd0,                   1'b0};
      vecs[19] = '{RS, 12'h344, 64'd0,                  64'd0,                   1'b0};

      rst_n = 1'b0;
      csr_valid = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0;
      trap = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
      mret = 1'b0; instret = 1'b0; timer_irq = 1'b0;

      // Outputs during reset: control low, valid read shows reset state.
      #12;
      trap = 1'b1; trap_cause = CAUSE_ECALL_M;
      csr_valid = 1'b1; csr_op = RS; csr_addr = 12'h300;
      #1;
      check("rst_redirect", {63'd0, redirect}, 64'd0);
      check("rst_mstatus", rdata, 64'h0000_000a_0000_1800);
      check("rst_irq_pending", {63'd0, irq_pending}, 64'd0);
      trap = 1'b0; csr_valid = 1'b0; csr_op = 2'b00;
      #9 rst_n = 1'b1;

      @(posedge clk);
      @(posedge clk);
      #1;
      csr_read("mcycle_after_reset", 12'hB00, 64'd2);

      for (int i = 0; i < 20; i++) begin
         csr_valid = 1'b1;
         csr_op    = vecs[i].op;
         csr_addr  = vecs[i].addr;
         csr_wdata = vecs[i].wdata;
         @(negedge clk);
         check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d_illegal", i), {63'd0, illegal}, {63'd0, vecs[i].exp_illegal});
         next_cycle();
      end
      csr_valid = 1'b0; csr_op = 2'b00;

      // Timer interrupt, vectored trap entry and mret.
      csr_op_drive(RW, 12'h300, 64'h8);
      csr_op_drive(RW, 12'h304, 64'h80);
      csr_op_drive(RW, 12'h305, 64'h8000_0001);
      timer_irq = 1'b1;
      @(negedge clk);
      check("irq_lag", {63'd0, irq_pending}, 64'd0);
      next_cycle();
      @(negedge clk);
      check("irq_pending", {63'd0, irq_pending}, 64'd1);
      next_cycle();
      trap = 1'b1; trap_cause = CAUSE_MTI; trap_pc = 64'h8000_0040; trap_tval = 64'h1234;
      @(negedge clk);
      check("mti_redirect", {63'd0, redirect}, 64'd1);
      check("mti_vector", redirect_pc, 64'h8000_001C);
      next_cycle();
      trap = 1'b0; timer_irq = 1'b0;
      @(negedge clk);
      check("irq_masked_after_trap", {63'd0, irq_pending}, 64'd0);
      next_cycle();
      csr_read("mti_mstatus", 12'h300, 64'h0000_000a_0000_1880);
      csr_read("mti_mepc", 12'h341, 64'h8000_0040);
      csr_read("mti_mcause", 12'h342, CAUSE_MTI);
      csr_read("mti_mtval", 12'h343, 64'h1234);
      mret = 1'b1;
      @(negedge clk);
      check("mret_redirect", {63'd0, redirect}, 64'd1);
      check("mret_pc", redirect_pc, 64'h8000_0040);
      next_cycle();
      mret = 1'b0;
      csr_read("mret_mstatus", 12'h300, 64'h0000_000a_0000_1888);

      // Trap beats a same-cycle CSR write; exceptions are not vectored.
      trap = 1'b1; trap_cause = CAUSE_ECALL_M; trap_pc = 64'h8000_0102; trap_tval = '0;
      csr_valid = 1'b1; csr_op = RW; csr_addr = 12'h341; csr_wdata = 64'd5;
      @(negedge clk);
      check("ecall_vector", redirect_pc, 64'h8000_0000);
      next_cycle();
      trap = 1'b0; csr_valid = 1'b0; csr_op = 2'b00;
      csr_read("ecall_mepc", 12'h341, 64'h8000_0100);
      csr_read("ecall_mcause", 12'h342, 64'd11);

      // Counter wrap and write-over-increment.
      csr_op_drive(RW, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
      csr_read("mcycle_max", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
      csr_read("mcycle_wrap", 12'hB00, 64'd0);
      instret = 1'b1;
      csr_op_drive(RW, 12'hB02, 64'd10);
      instret = 1'b0;
      csr_read("minstret_write_wins", 12'hB02, 64'd10);
      instret = 1'b1;
      next_cycle();
      instret = 1'b0;
      csr_read("minstret_inc", 12'hB02, 64'd11);

      // Asynchronous reset while a trap is being taken.
      csr_op_drive(RW, 12'h340, 64'h55);
      trap = 1'b1; trap_cause = CAUSE_ECALL_M; trap_pc = 64'h8000_0200;
      csr_valid = 1'b1; csr_op = RS; csr_addr = 12'h340; csr_wdata = '0;
      @(negedge clk);
      check("pre_reset_mscratch", rdata, 64'h55);
      #1 rst_n = 1'b0;
      #1;
      check("async_redirect", {63'd0, redirect}, 64'd0);
      check("async_redirect_pc", redirect_pc, 64'd0);
      check("async_mscratch", rdata, 64'd0);
      csr_addr = 12'h300;
      #1;
      check("async_mstatus", rdata, 64'h0000_000a_0000_1800);
      csr_addr = 12'h341;
      #1;
      check("async_mepc", rdata, 64'd0);
      trap = 1'b0; csr_valid = 1'b0; csr_op = 2'b00;
      @(posedge clk);
      #2 rst_n = 1'b1;
      next_cycle();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ysyx_22050710_csr_file.md
# ysyx_22050710_csr_file

Machine-mode CSR file with trap sequencing for the single-cycle ysyx_22050710 core. It replaces the four-register CSR block with a parametrised unit providing atomic csrrw/csrrs/csrrc, a full M-mode trap/mret state update, free-running counters, timer-interrupt pending logic and illegal-access detection. It sits beside the register file. It is read by the writeback mux, and its redirect output drives the PC-select logic.

## Interface
- XLEN, 64, data width of every CSR and data port
- MSTATUS_RESET, 64'ha00001800, mstatus value after reset (UXL/SXL=2, MPP=3)
- MTVEC_RESET, 0, mtvec value after reset
- HAS_COUNTERS, 1, 0 removes mcycle/minstret (reads return 0, addresses stay legal)
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_csr_valid  in  1  CSR instruction this cycle
- i_csr_op  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
- i_csr_addr  in  12  CSR address
- i_csr_wdata  in  XLEN  rs1 value or zero-extended uimm
- i_trap  in  1  synchronous exception or interrupt entry this cycle
- i_trap_cause  in  XLEN  mcause value (bit XLEN-1 = interrupt)
- i_trap_pc  in  XLEN  PC of trapping instruction
- i_trap_tval  in  XLEN  mtval value
- i_mret  in  1  mret retiring this cycle
- i_instret  in  1  one instruction retired this cycle
- i_timer_irq  in  1  level timer interrupt from CLINT
- o_rdata  out  XLEN  old value of addressed CSR, 0 when no valid access
- o_illegal  out  1  illegal CSR access
- o_redirect  out  1  take o_redirect_pc next cycle
- o_redirect_pc  out  XLEN  trap vector or mepc
- o_irq_pending  out  1  enabled timer interrupt pending

## Operation
- Implemented CSRs: mstatus 0x300, misa 0x301 (RO, RV64IM), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, minstret 0xB02, mhartid 0xF14 (RO, 0).
- New value: RW → wdata; RS → old|wdata; RC → old&~wdata; then apply the per-register write mask.
- Write masks (WARL):
  - mstatus: only MIE[3] and MPIE[7] are writable. MPP[12:11] always reads 2'b11.
  - mie: only MTIE[7] is writable.
  - mtvec: bit 1 forced 0.
  - mepc: bits [1:0] forced 0.
  - mip: not writable. MTIP[7] is i_timer_irq registered once.
- o_illegal is asserted when i_csr_valid and op≠00 and either:
  - the address is unimplemented, or
  - the access is a write to a read-only address (addr[11:10]==2'b11, or misa). RS/RC with wdata==0 is not a write.
  - An illegal access suppresses all CSR writes that cycle. The core converts it to a trap on the following cycle.
- Trap entry (i_trap), all updates at the same edge:
  - mepc ← trap_pc & ~3
  - mcause ← cause; mtval ← tval
  - MPIE ← MIE; MIE ← 0
  - o_redirect=1
  - o_redirect_pc = {mtvec[XLEN-1:2],2'b00}, plus 4×cause[5:0] when mtvec[1:0]==01 and cause is an interrupt.
- mret: MIE ← MPIE, MPIE ← 1, o_redirect=1, o_redirect_pc=mepc.
- Priority in one cycle: i_trap > i_mret > CSR write. The lower-priority actions are dropped.
- Counters:
  - mcycle increments every cycle.
  - minstret increments on i_instret.
  - A CSR write to a counter in the same cycle takes precedence over the increment.
  - Both wrap 2^XLEN−1 → 0.
- o_irq_pending = mstatus.MIE & mie.MTIE & mip.MTIP.

## Timing
- o_rdata, o_illegal, o_redirect, o_redirect_pc and o_irq_pending are combinational from current state and inputs (zero latency). Written values are visible on the next cycle.
- mip.MTIP lags i_timer_irq by exactly 1 cycle.
- A read-modify-write (RS/RC) returns the pre-write value and is atomic within one cycle.
- Reset (asynchronous, any time, including mid-trap):
  - mstatus=MSTATUS_RESET, mtvec=MTVEC_RESET, all other state 0.
  - Outputs fall to 0 immediately, except o_rdata, which reflects reset state for a valid read.
- First counter increment occurs at the first rising edge after deassertion.

## Structure
- Shared package ysyx_22050710_csr_pkg holds:
  - CSR address localparams
  - op encodings
  - mstatus/mie/mip bit positions
  - cause codes (ECALL_M=11, MTI=7|interrupt bit)
- One sub-module, ysyx_22050710_csr_counter: XLEN counter with increment enable, write enable/data and async active-low reset. Instantiated twice, under generate when HAS_COUNTERS.

## Test plan
- Reset, then read 0x300 → 0xa00001800. Read 0xF14 → 0. Two cycles after reset release, mcycle reads 2.
- RW 0x340 ← 0xdead_beef, then RS 0x340 with 0xF0000 → o_rdata=0xdeadbeef and new value 0xdeafbeef. Then RC with 0xdeafbeef → 0.
- Set MIE and MTIE, raise i_timer_irq → o_irq_pending high 1 cycle later. Trap with cause 0x8000…0007 and mtvec=0x8000_0001 → redirect 0x8000_001C, MIE=0, MPIE=1. Then mret → redirect to mepc, MIE=1.
- RW write to 0xF14 → o_illegal=1, no state change. RS to 0xF14 with wdata=0 → legal. Read 0x7C0 → illegal.
- Same cycle: i_trap (cause 11, pc 0x8000_0102) with RW mepc ← 5 → mepc=0x8000_0100, CSR write dropped.
- Write mcycle ← 0xFFFF_FFFF_FFFF_FFFF → reads 0 the cycle after next. Pulse i_rst_n low mid-trap → all state at reset values asynchronously.
